// File: rtl/ti_share_pkg.sv
// Shared types and helpers for the threshold-implementation share controller
// and its recombination logic.
package ti_share_pkg;

  localparam int BLK_W_DEF  = 128;
  localparam int KEY_W_DEF  = 128;
  localparam int SH_W       = BLK_W_DEF + KEY_W_DEF;
  localparam int MAX_SHARES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // XOR of one bit column across all shares; unused share positions are zero.
  function automatic logic share_xor(input logic [MAX_SHARES-1:0] col);
    return ^col;
  endfunction

endpackage

// File: rtl/ti_share_recomb.sv
// Combinational recombination of N Boolean shares of W bits each.
module ti_share_recomb
  import ti_share_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 128
) (
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  logic [MAX_SHARES-1:0] col;

  always_comb begin
    dout = '0;
    col  = '0;
    for (int i = 0; i < W; i++) begin
      col = '0;
      for (int s = 0; s < N; s++) col[s] = din[s*W + i];
      dout[i] = share_xor(col);
    end
  end

endmodule

// File: rtl/ti_share_ctrl.sv
// Share split / recombination controller for a masked SIMON core with batch runs.
// Optional core-latency measurement on Lat: define TI_SHARE_CTRL_LAT_CNT_EN.
module ti_share_ctrl
  import ti_share_pkg::*;
#(
  parameter int BLK_W  = BLK_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int SHARES = 3,
  parameter int RPT_W  = 16
) (
  input  logic                                 CLK,
  input  logic                                 RSTn,
  input  logic                                 EN,
  input  logic [BLK_W+KEY_W-1:0]               Din,
  input  logic                                 Drdy,
  input  logic [RPT_W-1:0]                     Rpt,
  input  logic [(SHARES-1)*(BLK_W+KEY_W)-1:0]  Rnd,
  output logic                                 Rnd_ack,
  output logic [BLK_W-1:0]                     Dout,
  output logic                                 Dvld,
  output logic                                 BSY,
  output logic                                 Trig,
  output logic [31:0]                          Lat,
  output logic [SHARES*(BLK_W+KEY_W)-1:0]      core_din,
  output logic                                 core_drdy,
  input  logic [SHARES*BLK_W-1:0]              core_dout,
  input  logic                                 core_dvld
);

  localparam int SW = BLK_W + KEY_W;

  state_e                state, nxt;
  logic [SW-1:0]         din_q, src, share0;
  logic [RPT_W-1:0]      rem;
  logic [BLK_W-1:0]      ct;
  logic [MAX_SHARES-1:0] col;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (Drdy) nxt = ST_LOAD;
      ST_LOAD: nxt = ST_WAIT;
      ST_WAIT: if (core_dvld) nxt = ST_OUT;
      ST_OUT:  nxt = (rem > RPT_W'(1)) ? ST_LOAD : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    if (!EN) nxt = ST_IDLE;
  end

  // First run of a batch splits the live Din; later runs reuse the latched copy.
  assign src = (state == ST_IDLE) ? Din : din_q;

  always_comb begin
    share0 = '0;
    col    = '0;
    for (int i = 0; i < SW; i++) begin
      col    = '0;
      col[0] = src[i];
      for (int s = 1; s < SHARES; s++) col[s] = Rnd[(s-1)*SW + i];
      share0[i] = share_xor(col);
    end
  end

  ti_share_recomb #(.N(SHARES), .W(BLK_W)) u_recomb (
    .din  (core_dout),
    .dout (ct)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      din_q     <= '0;
      rem       <= '0;
      core_din  <= '0;
      core_drdy <= 1'b0;
      Rnd_ack   <= 1'b0;
      Trig      <= 1'b0;
      BSY       <= 1'b0;
      Dvld      <= 1'b0;
      Dout      <= '0;
    end else begin
      state     <= nxt;
      core_drdy <= (nxt == ST_LOAD);
      Rnd_ack   <= (nxt == ST_LOAD);
      Trig      <= (nxt == ST_LOAD) || (nxt == ST_WAIT);
      BSY       <= (nxt != ST_IDLE);
      Dvld      <= (nxt == ST_OUT);
      if (nxt == ST_LOAD) begin
        core_din[SW-1:0]        <= share0;
        core_din[SHARES*SW-1:SW] <= Rnd;
      end
      if (state == ST_IDLE && nxt == ST_LOAD) begin
        din_q <= Din;
        rem   <= (Rpt == '0) ? RPT_W'(1) : Rpt;
      end else if (state == ST_OUT && rem != '0) begin
        rem <= rem - RPT_W'(1);
      end
      if (!EN) rem <= '0;
      if (nxt == ST_OUT) Dout <= ct;
    end
  end

`ifdef TI_SHARE_CTRL_LAT_CNT_EN
  logic [31:0] lat_cnt, lat_inc;

  assign lat_inc = (&lat_cnt) ? lat_cnt : lat_cnt + 32'd1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lat_cnt <= '0;
      Lat     <= '0;
    end else begin
      if (state == ST_LOAD)      lat_cnt <= '0;
      else if (state == ST_WAIT) lat_cnt <= lat_inc;
      if (state == ST_WAIT && nxt == ST_OUT) Lat <= lat_inc;
    end
  end
`else
  assign Lat = '0;
`endif

endmodule

// File: tb/tb_ti_share_ctrl.sv
// Directed bench for ti_share_ctrl: a 3-share DUT with a 40-cycle behavioural
// SIMON128/128 core and a 2-share DUT with a 3-cycle core.
module tb_ti_share_ctrl;

  localparam int LAT_A = 40;
  localparam int LAT_B = 3;
  localparam logic [255:0] TV = 256'h63736564207372656c6c657661727420_0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  // DUT A: SHARES=3
  logic         EN_a, Drdy_a, Rnd_ack_a, Dvld_a, BSY_a, Trig_a, core_drdy_a;
  logic         core_dvld_a = 1'b0;
  logic [255:0] Din_a;
  logic [15:0]  Rpt_a;
  logic [511:0] Rnd_a;
  logic [127:0] Dout_a;
  logic [31:0]  Lat_a;
  logic [767:0] core_din_a;
  logic [383:0] core_dout_a = '0;

  // DUT B: SHARES=2
  logic         EN_b, Drdy_b, Rnd_ack_b, Dvld_b, BSY_b, Trig_b, core_drdy_b;
  logic         core_dvld_b = 1'b0;
  logic [255:0] Din_b;
  logic [15:0]  Rpt_b;
  logic [255:0] Rnd_b;
  logic [127:0] Dout_b;
  logic [31:0]  Lat_b;
  logic [511:0] core_din_b;
  logic [255:0] core_dout_b = '0;

  ti_share_ctrl #(.BLK_W(128), .KEY_W(128), .SHARES(3), .RPT_W(16)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .EN(EN_a), .Din(Din_a), .Drdy(Drdy_a), .Rpt(Rpt_a),
    .Rnd(Rnd_a), .Rnd_ack(Rnd_ack_a), .Dout(Dout_a), .Dvld(Dvld_a), .BSY(BSY_a),
    .Trig(Trig_a), .Lat(Lat_a), .core_din(core_din_a), .core_drdy(core_drdy_a),
    .core_dout(core_dout_a), .core_dvld(core_dvld_a)
  );

  ti_share_ctrl #(.BLK_W(128), .KEY_W(128), .SHARES(2), .RPT_W(16)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .EN(EN_b), .Din(Din_b), .Drdy(Drdy_b), .Rpt(Rpt_b),
    .Rnd(Rnd_b), .Rnd_ack(Rnd_ack_b), .Dout(Dout_b), .Dvld(Dvld_b), .BSY(BSY_b),
    .Trig(Trig_b), .Lat(Lat_b), .core_din(core_din_b), .core_drdy(core_drdy_b),
    .core_dout(core_dout_b), .core_dvld(core_dvld_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference SIMON128/128 encryption of {plaintext, key}.
  function automatic logic [127:0] simon(input logic [255:0] d);
    logic [63:0] k [0:67];
    logic [63:0] x, y, t;
    logic [0:61] z;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = d[63:0];
    k[1] = d[127:64];
    for (int i = 0; i < 66; i++) begin
      t = {k[i+1][2:0], k[i+1][63:3]};
      t = t ^ {t[0], t[63:1]};
      k[i+2] = ~k[i] ^ t ^ 64'd3 ^ {63'd0, z[i % 62]};
    end
    x = d[255:192];
    y = d[191:128];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]} ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Behavioural masked cores: recombine input, encrypt, re-share with fresh masks.
  logic [127:0] ct_a, ct_b;
  int cnt_a = 0, cnt_b = 0;
  logic [255:0] mk_a, mk_b;

  always @(posedge CLK) begin
    if (core_drdy_a) begin
      ct_a        <= simon(core_din_a[255:0] ^ core_din_a[511:256] ^ core_din_a[767:512]);
      cnt_a       <= LAT_A;
      core_dvld_a <= 1'b0;
    end else if (cnt_a != 0) begin
      cnt_a       <= cnt_a - 1;
      core_dvld_a <= (cnt_a == 2);
      if (cnt_a == 2) begin
        mk_a = r256();
        core_dout_a <= {mk_a[255:128], mk_a[127:0], ct_a ^ mk_a[255:128] ^ mk_a[127:0]};
      end
    end
  end

  always @(posedge CLK) begin
    if (core_drdy_b) begin
      ct_b        <= simon(core_din_b[255:0] ^ core_din_b[511:256]);
      cnt_b       <= LAT_B;
      core_dvld_b <= 1'b0;
    end else if (cnt_b != 0) begin
      cnt_b       <= cnt_b - 1;
      core_dvld_b <= (cnt_b == 2);
      if (cnt_b == 2) begin
        mk_b = r256();
        core_dout_b <= {mk_b[127:0], ct_b ^ mk_b[127:0]};
      end
    end
  end

  // Monitor on DUT A: share split and result of every LOAD / OUT.
  logic [255:0] din_exp = TV;
  logic [127:0] ct_exp = CT;
  logic [511:0] rp;
  logic [767:0] last_cd = '0;
  int cyc = 0, ack_cnt = 0, dvld_cnt = 0, bad = 0, same = 0;
  int dv_cyc[$];

  always @(posedge CLK) begin
    rp = Rnd_a;
    cyc++;
    #1;
    if (Rnd_ack_a === 1'b1) begin
      ack_cnt++;
      if ((core_din_a[255:0] ^ core_din_a[511:256] ^ core_din_a[767:512]) !== din_exp) bad++;
      if (core_din_a[767:256] !== rp) bad++;
      if (core_din_a === last_cd) same++;
      last_cd = core_din_a;
    end
    if (Dvld_a === 1'b1) begin
      dvld_cnt++;
      if (Dout_a !== ct_exp) bad++;
      dv_cyc.push_back(cyc);
    end
  end

  initial begin
    int n, trig_n, a0, d0, q0, s0;
    logic [511:0] r0;
    logic [255:0] tv2, rb;

    RSTn = 1'b0; EN_a = 1'b0; Drdy_a = 1'b0; Din_a = '0; Rpt_a = '0; Rnd_a = '0;
    EN_b = 1'b0; Drdy_b = 1'b0; Din_b = '0; Rpt_b = '0; Rnd_b = '0;
    repeat (2) step();
    chk("rst_bsy",   {255'd0, BSY_a}, '0);
    chk("rst_trig",  {255'd0, Trig_a}, '0);
    chk("rst_dvld",  {255'd0, Dvld_a}, '0);
    chk("rst_cdrdy", {255'd0, core_drdy_a}, '0);
    chk("rst_ack",   {255'd0, Rnd_ack_a}, '0);
    chk("rst_dout",  {128'd0, Dout_a}, '0);
    chk("rst_lat",   {224'd0, Lat_a}, '0);
    chk("rst_cdin",  {255'd0, |core_din_a}, '0);
    chk("simon_ref", {128'd0, simon(TV)}, {128'd0, CT});

    RSTn = 1'b1; EN_a = 1'b1; EN_b = 1'b1;
    step();

    // Single run
    r0 = {r256(), r256()};
    Din_a = TV; Rpt_a = 16'd1; Rnd_a = r0; Drdy_a = 1'b1;
    step();
    chk("load_cdrdy", {255'd0, core_drdy_a}, 256'd1);
    chk("load_ack",   {255'd0, Rnd_ack_a}, 256'd1);
    chk("load_bsy",   {255'd0, BSY_a}, 256'd1);
    chk("load_trig",  {255'd0, Trig_a}, 256'd1);
    chk("load_sh1",   core_din_a[511:256], r0[255:0]);
    chk("load_sh2",   core_din_a[767:512], r0[511:256]);
    chk("load_sh0",   core_din_a[255:0], TV ^ r0[255:0] ^ r0[511:256]);
    Drdy_a = 1'b0; Rnd_a = {r256(), r256()}; Din_a = r256();
    trig_n = 1;
    step();
    chk("wait_cdrdy", {255'd0, core_drdy_a}, '0);
    chk("wait_ack",   {255'd0, Rnd_ack_a}, '0);
    n = 2;
    while (Dvld_a !== 1'b1 && n < 200) begin
      if (Trig_a === 1'b1) trig_n++;
      step();
      n++;
    end
    chk("dvld_cycle", 256'(n), 256'(LAT_A + 2));
    chk("run1_dout",  {128'd0, Dout_a}, {128'd0, CT});
    chk("out_trig",   {255'd0, Trig_a}, '0);
    chk("trig_len",   256'(trig_n), 256'(LAT_A + 1));
`ifdef TI_SHARE_CTRL_LAT_CNT_EN
    chk("lat", {224'd0, Lat_a}, 256'(LAT_A));
`else
    chk("lat", {224'd0, Lat_a}, '0);
`endif
    step();
    chk("run1_pulse", {255'd0, Dvld_a}, '0);
    chk("run1_idle",  {255'd0, BSY_a}, '0);
    chk("dout_hold",  {128'd0, Dout_a}, {128'd0, CT});

    // Batch of 5 with Rnd changing every cycle
    a0 = ack_cnt; d0 = dvld_cnt; q0 = dv_cyc.size(); s0 = same;
    Din_a = TV; Rpt_a = 16'd5; Rnd_a = {r256(), r256()}; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    n = 1;
    while (BSY_a === 1'b1 && n < 1000) begin
      Rnd_a = {r256(), r256()};
      step();
      n++;
    end
    chk("batch_dvld", 256'(dvld_cnt - d0), 256'd5);
    chk("batch_ack",  256'(ack_cnt - a0), 256'd5);
    chk("batch_fresh", 256'(same - s0), '0);
    if (dv_cyc.size() >= q0 + 5) begin
      chk("batch_space", 256'(dv_cyc[q0+1] - dv_cyc[q0]), 256'(LAT_A + 2));
      chk("batch_bsy",   256'(cyc - dv_cyc[q0+4]), 256'd1);
    end else begin
      chk("batch_count", 256'(dv_cyc.size() - q0), 256'd5);
    end
    chk("mon_bad1", 256'(bad), '0);

    // Drdy during WAIT is ignored
    a0 = ack_cnt; d0 = dvld_cnt;
    Din_a = TV; Rpt_a = 16'd1; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    repeat (5) step();
    Din_a = r256(); Rpt_a = 16'd3; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    n = 0;
    while (BSY_a === 1'b1 && n < 200) begin step(); n++; end
    chk("wdrdy_dvld", 256'(dvld_cnt - d0), 256'd1);
    chk("wdrdy_ack",  256'(ack_cnt - a0), 256'd1);
    chk("wdrdy_dout", {128'd0, Dout_a}, {128'd0, CT});

    // EN dropped in WAIT
    d0 = dvld_cnt;
    Din_a = TV; Rpt_a = 16'd2; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    repeat (10) step();
    EN_a = 1'b0;
    step();
    chk("en_bsy",  {255'd0, BSY_a}, '0);
    chk("en_trig", {255'd0, Trig_a}, '0);
    EN_a = 1'b1;
    repeat (50) step();
    chk("en_nodvld", 256'(dvld_cnt - d0), '0);
    tv2 = r256();
    din_exp = tv2; ct_exp = simon(tv2);
    Din_a = tv2; Rpt_a = 16'd1; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    n = 0;
    while (BSY_a === 1'b1 && n < 200) begin step(); n++; end
    chk("en_rerun_dvld", 256'(dvld_cnt - d0), 256'd1);
    chk("en_rerun_dout", {128'd0, Dout_a}, {128'd0, ct_exp});

    // Reset asserted mid-WAIT
    Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    repeat (10) step();
    RSTn = 1'b0;
    #1;
    chk("arst_bsy",  {255'd0, BSY_a}, '0);
    chk("arst_trig", {255'd0, Trig_a}, '0);
    chk("arst_dout", {128'd0, Dout_a}, '0);
    chk("arst_cdin", {255'd0, |core_din_a}, '0);
    chk("arst_lat",  {224'd0, Lat_a}, '0);
    step();
    RSTn = 1'b1;
    repeat (50) step();
    d0 = dvld_cnt;
    din_exp = TV; ct_exp = CT;
    Din_a = TV; Rpt_a = 16'd1; Drdy_a = 1'b1;
    step();
    Drdy_a = 1'b0;
    n = 0;
    while (BSY_a === 1'b1 && n < 200) begin step(); n++; end
    chk("arst_rerun_dvld", 256'(dvld_cnt - d0), 256'd1);
    chk("arst_rerun_dout", {128'd0, Dout_a}, {128'd0, CT});
    chk("mon_bad2", 256'(bad), '0);

    // SHARES=2, Rpt=0 means one run
    rb = r256();
    Din_b = TV; Rpt_b = 16'd0; Rnd_b = rb; Drdy_b = 1'b1;
    step();
    Drdy_b = 1'b0; Rnd_b = r256();
    chk("b_recomb", core_din_b[255:0] ^ core_din_b[511:256], TV);
    chk("b_sh1",    core_din_b[511:256], rb);
    n = 0; d0 = 0;
    while (BSY_b === 1'b1 && n < 100) begin
      if (Dvld_b === 1'b1) begin
        d0++;
        chk("b_dout", {128'd0, Dout_b}, {128'd0, CT});
      end
      step();
      n++;
    end
    chk("b_runs", 256'(d0), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
